ttt_move_ctrl: RTL and testbench

TTT_MOVE_CTRL -- requirements
Module: ttt_move_ctrl

---
 rtl/ttt_move_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ttt_move_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_move_ctrl
//
// Purpose: player-side move controller for a 3x3 tic-tac-toe game. It moves a
// cursor over the board from button pulses, keeps a record of occupied cells,
// and presents each accepted move to the downstream tttv2 judge for exactly
// two cycles. It tracks whose turn it is and how many moves were made, and it
// stops when the judge reports game over or when the board is full.
//
// Ports:
//   clk                    in   single clock, rising edge
//   reset                  in   asynchronous, active-low clear of all state
//   btn_left / btn_right   in   cursor_x step -1 / +1, wrapping 0..2
//   btn_up / btn_down      in   cursor_y step -1 / +1, wrapping 0..2
//   btn_confirm            in   request a move at the cursor (beats cursor buttons)
//   stop_game              in   game-over flag from tttv2
//   cursor_x, cursor_y     out  cursor cell (x = row, y = column)
//   data_in_x, data_in_y   out  coordinates of the move presented to tttv2
//   player                 out  side to move (0 or 1)
//   enable                 out  high while a move is presented (2 cycles)
//   move_count             out  accepted moves, 0..9
//   reject                 out  one-cycle pulse for a confirm on an occupied cell
//   game_over              out  high once the game has ended
// ---------------------------------------------------------------------------
module ttt_move_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_confirm,
    input  logic       stop_game,
    output logic [1:0] cursor_x,
    output logic [1:0] cursor_y,
    output logic [1:0] data_in_x,
    output logic [1:0] data_in_y,
    output logic [1:0] player,
    output logic       enable,
    output logic [3:0] move_count,
    output logic       reject,
    output logic       game_over
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_HOLD  = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t     r_state,   w_state_next;
    logic [1:0] r_cur_x,   w_cur_x_next;
    logic [1:0] r_cur_y,   w_cur_y_next;
    logic [1:0] r_din_x,   w_din_x_next;
    logic [1:0] r_din_y,   w_din_y_next;
    logic       r_player,  w_player_next;
    logic [3:0] r_count,   w_count_next;
    logic [8:0] r_mask,    w_mask_next;
    logic       r_reject,  w_reject_next;

    logic [3:0] w_cell_idx;
    logic       w_cell_busy;
    logic [3:0] w_count_inc;

    // One wrapping step on a 0..2 axis; opposing buttons together cancel.
    function automatic logic [1:0] step_axis(input logic [1:0] v,
                                             input logic       inc,
                                             input logic       dec);
        logic [1:0] res;
        res = v;
        if (inc && !dec) begin
            res = (v == 2'd2) ? 2'd0 : v + 2'd1;
        end else if (dec && !inc) begin
            res = (v == 2'd0) ? 2'd2 : v - 2'd1;
        end
        return res;
    endfunction

    // Row-major cell index: row * 3 + column.
    assign w_cell_idx  = ({2'b00, r_cur_x} * 4'd3) + {2'b00, r_cur_y};
    assign w_cell_busy = r_mask[w_cell_idx];
    assign w_count_inc = (r_count < 4'd9) ? r_count + 4'd1 : r_count;

    always_comb begin
        w_state_next  = r_state;
        w_cur_x_next  = r_cur_x;
        w_cur_y_next  = r_cur_y;
        w_din_x_next  = r_din_x;
        w_din_y_next  = r_din_y;
        w_player_next = r_player;
        w_count_next  = r_count;
        w_mask_next   = r_mask;
        w_reject_next = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (stop_game) begin
                    w_state_next = S_OVER;
                end else if (btn_confirm) begin
                    if (w_cell_busy) begin
                        w_reject_next = 1'b1;
                    end else begin
                        w_din_x_next = r_cur_x;
                        w_din_y_next = r_cur_y;
                        w_mask_next  = r_mask | (9'd1 << w_cell_idx);
                        w_state_next = S_ISSUE;
                    end
                end else begin
                    w_cur_x_next = step_axis(r_cur_x, btn_right, btn_left);
                    w_cur_y_next = step_axis(r_cur_y, btn_down, btn_up);
                end
            end
            S_ISSUE: begin
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                // Move is committed as the presentation window closes.
                w_player_next = ~r_player;
                w_count_next  = w_count_inc;
                if (stop_game || (w_count_inc == 4'd9)) begin
                    w_state_next = S_OVER;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_OVER: begin
                w_state_next = S_OVER;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_cur_x  <= 2'd0;
            r_cur_y  <= 2'd0;
            r_din_x  <= 2'd0;
            r_din_y  <= 2'd0;
            r_player <= 1'b0;
            r_count  <= 4'd0;
            r_mask   <= 9'd0;
            r_reject <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_cur_x  <= w_cur_x_next;
            r_cur_y  <= w_cur_y_next;
            r_din_x  <= w_din_x_next;
            r_din_y  <= w_din_y_next;
            r_player <= w_player_next;
            r_count  <= w_count_next;
            r_mask   <= w_mask_next;
            r_reject <= w_reject_next;
        end
    end

    assign cursor_x   = r_cur_x;
    assign cursor_y   = r_cur_y;
    assign data_in_x  = r_din_x;
    assign data_in_y  = r_din_y;
    assign player     = {1'b0, r_player};
    assign move_count = r_count;
    assign reject     = r_reject;
    assign enable     = (r_state == S_ISSUE) || (r_state == S_HOLD);
    assign game_over  = (r_state == S_OVER);

endmodule

// File: tb/tb_ttt_move_ctrl.sv
module tb_ttt_move_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_left, btn_right, btn_up, btn_down, btn_confirm, stop_game;
    logic [1:0] cursor_x, cursor_y, data_in_x, data_in_y, player;
    logic       enable, reject, game_over;
    logic [3:0] move_count;

    always #5 clk = ~clk;

    ttt_move_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_confirm(btn_confirm),
        .stop_game  (stop_game),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .data_in_x  (data_in_x),
        .data_in_y  (data_in_y),
        .player     (player),
        .enable     (enable),
        .move_count (move_count),
        .reject     (reject),
        .game_over  (game_over)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Game-level reference: cursor, board contents (0 empty, 1/2 = side 0/1),
    // turn, move count, last issued move, and the tttv2 verdict.
    int mx, my, mdx, mdy, mplayer, mcount;
    bit mover, mstop;
    int occ[9];

    function automatic bit has_win(input int p);
        bit w;
        w = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (occ[k*3] == p && occ[k*3+1] == p && occ[k*3+2] == p) w = 1'b1;
            if (occ[k] == p && occ[k+3] == p && occ[k+6] == p) w = 1'b1;
        end
        if (occ[0] == p && occ[4] == p && occ[8] == p) w = 1'b1;
        if (occ[2] == p && occ[4] == p && occ[6] == p) w = 1'b1;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input bit exp_rej, input bit exp_en);
        chk({tag, "/cursor_x"},   cursor_x,   mx);
        chk({tag, "/cursor_y"},   cursor_y,   my);
        chk({tag, "/data_in_x"},  data_in_x,  mdx);
        chk({tag, "/data_in_y"},  data_in_y,  mdy);
        chk({tag, "/player"},     player,     mplayer);
        chk({tag, "/move_count"}, move_count, mcount);
        chk({tag, "/enable"},     enable,     exp_en);
        chk({tag, "/reject"},     reject,     exp_rej);
        chk({tag, "/game_over"},  game_over,  mover);
        $display("txn %-12s cur=(%0d,%0d) din=(%0d,%0d) pl=%0d cnt=%0d en=%0b rej=%0b over=%0b",
                 tag, cursor_x, cursor_y, data_in_x, data_in_y, player, move_count,
                 enable, reject, game_over);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_confirm = 0;
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 0; mdy = 0; mplayer = 0; mcount = 0;
        mover = 0; mstop = 0;
        for (int k = 0; k < 9; k++) occ[k] = 0;
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b0;
        clr();
        stop_game = 1'b0;
        model_reset();
        #1;
        chk_state(tag, 0, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // One user action in the game, checked cycle by cycle against the model.
    task automatic cycle(input string tag, input bit l, input bit r,
                         input bit u, input bit d, input bit c);
        int idx;
        btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_confirm = c;
        if (mover) begin
            step(); clr();
            chk_state({tag, "/over"}, 0, 0);
        end else if (mstop) begin
            step(); clr();
            mover = 1;
            chk_state({tag, "/stop"}, 0, 0);
        end else if (c) begin
            idx = mx * 3 + my;
            if (occ[idx] != 0) begin
                step(); clr();
                chk_state({tag, "/rej"}, 1, 0);
                step();
                chk_state({tag, "/rej_end"}, 0, 0);
            end else begin
                step(); clr();
                mdx = mx; mdy = my;
                chk_state({tag, "/issue"}, 0, 1);
                occ[idx] = mplayer + 1;
                step();
                chk_state({tag, "/hold"}, 0, 1);
                if (has_win(mplayer + 1)) begin
                    mstop = 1;
                    stop_game = 1'b1;
                end
                step();
                mplayer = 1 - mplayer;
                if (mcount < 9) mcount++;
                if (mstop || mcount == 9) mover = 1;
                chk_state({tag, "/done"}, 0, 0);
            end
        end else begin
            mx = (mx + int'(r) - int'(l) + 3) % 3;
            my = (my + int'(d) - int'(u) + 3) % 3;
            step(); clr();
            chk_state(tag, 0, 0);
        end
    endtask

    task automatic goto(input int tx, input int ty);
        for (int k = 0; k < 3 && mx != tx; k++) cycle("nav", 0, 1, 0, 0, 0);
        for (int k = 0; k < 3 && my != ty; k++) cycle("nav", 0, 0, 0, 1, 0);
    endtask

    task automatic play(input int tx, input int ty);
        goto(tx, ty);
        cycle("move", 0, 0, 0, 0, 1);
    endtask

    initial begin
        clr();
        stop_game = 1'b0;
        do_reset("reset");

        // Cursor wrap and cancellation.
        cycle("right1", 0, 1, 0, 0, 0);
        cycle("right2", 0, 1, 0, 0, 0);
        cycle("right3", 0, 1, 0, 0, 0);
        chk("wrap_right", cursor_x, 0);
        cycle("left1", 1, 0, 0, 0, 0);
        chk("wrap_left", cursor_x, 2);
        cycle("up_down", 0, 0, 1, 1, 0);
        cycle("left_right", 1, 1, 0, 0, 0);
        cycle("up_wrap", 0, 0, 1, 0, 0);
        chk("wrap_up", cursor_y, 2);

        // Move issue at (1,2), then rejection on the same cell.
        goto(1, 2);
        cycle("c12", 0, 0, 0, 0, 1);
        chk("after_move_player", player, 1);
        chk("after_move_count", move_count, 1);
        cycle("c12_again", 0, 1, 1, 0, 1);

        // Randomized play with tttv2 behaviour modelled by the bench.
        for (int i = 0; i < 600 && !mover; i++) begin
            cycle("rnd", $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < 6; i++) begin
            cycle("rnd_over", $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
                  $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0, 1'b1);
        end

        // Row-0 win for side 0.
        do_reset("reset_win");
        play(0, 0); play(1, 0); play(0, 1); play(1, 1); play(0, 2);
        chk("win_stop_game", stop_game, 1);
        chk("win_game_over", game_over, 1);
        chk("win_count", move_count, 5);
        play(2, 2);

        // Draw: full board, nobody wins.
        do_reset("reset_draw");
        play(0, 0); play(0, 1); play(0, 2); play(1, 1); play(1, 0);
        play(1, 2); play(2, 1); play(2, 0); play(2, 2);
        chk("draw_count", move_count, 9);
        chk("draw_over", game_over, 1);
        chk("draw_no_stop", stop_game, 0);
        cycle("draw_after", 0, 0, 0, 0, 1);

        // stop_game while idle ends the game; the confirm in that cycle is dropped.
        do_reset("reset_stop");
        mstop = 1; stop_game = 1'b1;
        cycle("idle_stop", 0, 0, 0, 0, 1);

        // Reset during HOLD aborts the move; the same cell is accepted afterwards.
        do_reset("reset_mid");
        goto(1, 1);
        btn_confirm = 1'b1;
        step(); clr();
        step();
        chk("mid_hold_enable", enable, 1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        chk_state("mid_reset", 0, 0);
        @(negedge clk);
        reset = 1'b1;
        goto(1, 1);
        cycle("mid_retry", 0, 0, 0, 0, 1);
        chk("mid_retry_count", move_count, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
